register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/mips_pkg.sv | 15 +
 rtl/regfile_mem.sv | 31 +++
 rtl/register_file.sv | 121 ++++++++++++
 tb/tb_register_file.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file slice.
//   DATA_W     : register / ALU operand width
//   REG_ADDR_W : register index width
//   NUM_REGS   : number of architectural registers
//   rf_state_e : register file init FSM (CLEAR walk, then RUN)
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;
endpackage

// File: rtl/regfile_mem.sv
// Storage array for the register file: NUM_RD combinational read ports and
// one synchronous write port. No reset, so it can map onto RAM.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write value
//   raddr : packed read indices, one per read port
//   rdata : packed read data, one per read port (raw, no r0 masking)
module regfile_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rdata[p] = mem[raddr[p]];
  end
endmodule

// File: rtl/register_file.sv
// MIPS register file: 2**ADDR_W entries, r0 hard-wired to zero, two
// combinational read ports, one write port with overflow suppression.
// After reset a CLEAR walk zeroes r1..rN one per cycle; ready rises in the
// first RUN cycle. A write suppressed by overflow raises trapped for one cycle.
// Optional macro REGFILE_BYPASS_EN forwards a committing write to a read
// port addressing the same register in the same cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   readReg1/2           : source indices; readData1/2 : operands
//   writeReg, writeData  : destination index / value
//   regWrite             : write request
//   overflow,ovfSuppress : ALU overflow and "drop on overflow" qualifier
//   ready                : initialised, accepting writes
//   trapped              : one-cycle pulse per suppressed write
module register_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  input  logic              overflow,
  input  logic              ovfSuppress,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              ready,
  output logic              trapped
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_nxt;
  logic              trap_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0][ADDR_W-1:0] mem_raddr;
  logic [1:0][DATA_W-1:0] mem_rdata;

  logic wr_req, wr_sup, wr_commit;

  // Write qualification: only in RUN, never to r0.
  assign wr_req    = (state == RUN) && regWrite && (writeReg != '0);
  assign wr_sup    = ovfSuppress && overflow;
  assign wr_commit = wr_req && !wr_sup;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= FIRST_IDX;
      trapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_nxt;
      trapped <= trap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_idx;
    trap_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = writeReg;
    mem_wdata = writeData;
    case (state)
      CLEAR: begin
        // r0 is never stored to; walk starts at 1 and ends at the top entry.
        mem_we    = !rst;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        clr_nxt   = clr_idx + FIRST_IDX;
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        mem_we   = wr_commit && !rst;
        trap_nxt = wr_req && wr_sup;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign mem_raddr[0] = readReg1;
  assign mem_raddr[1] = readReg2;

  regfile_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Reads are zero while clearing (array content is still stale) and for r0.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (state == RUN && readReg1 != '0) readData1 = mem_rdata[0];
    if (state == RUN && readReg2 != '0) readData2 = mem_rdata[1];
`ifdef REGFILE_BYPASS_EN
    // wr_commit already excludes CLEAR, r0 and suppressed writes.
    if (wr_commit && writeReg == readReg1) readData1 = writeData;
    if (wr_commit && writeReg == readReg2) readData2 = writeData;
`endif
  end

  assign ready = (state == RUN);
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] readReg1, readReg2, writeReg;
  logic [DW-1:0] writeData;
  logic          regWrite, overflow, ovfSuppress;
  logic [DW-1:0] readData1, readData2;
  logic          ready, trapped;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .overflow(overflow), .ovfSuppress(ovfSuppress),
    .readData1(readData1), .readData2(readData2),
    .ready(ready), .trapped(trapped)
  );

  always #5 clk = ~clk;

  typedef enum int { K_RD1, K_RD2, K_RDY, K_TRP } kind_e;
  typedef struct {
    kind_e       kind;
    logic [DW-1:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always begin
    @(ev_chk);
    while (q.size() > 0) begin
      exp_t e;
      logic [DW-1:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD1:   act = readData1;
        K_RD2:   act = readData2;
        K_RDY:   act = {{(DW-1){1'b0}}, ready};
        default: act = {{(DW-1){1'b0}}, trapped};
      endcase
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
    end
  end

  task automatic chk_now(input logic [DW-1:0] act, input logic [DW-1:0] v, input string nm);
    n_chk++;
    if (act === v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, v);
  endtask

  task automatic expect_v(input kind_e k, input logic [DW-1:0] v, input string nm);
    exp_t e;
    e.kind = k; e.exp = v; e.name = nm;
    q.push_back(e);
    -> ev_chk;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic ovf, input logic sup);
    writeReg = a; writeData = d; overflow = ovf; ovfSuppress = sup;
    regWrite = 1'b1;
    tick();
    regWrite = 1'b0; overflow = 1'b0; ovfSuppress = 1'b0;
  endtask

  task automatic rd_both(input logic [AW-1:0] a, input logic [DW-1:0] v, input string nm);
    readReg1 = a; readReg2 = a;
    #1;
    expect_v(K_RD1, v, {nm, ".rd1"});
    expect_v(K_RD2, v, {nm, ".rd2"});
    tick();
  endtask

  task automatic ready_walk(input string nm);
    for (int c = 1; c <= 32; c++) begin
      if (c == 32) regWrite = 1'b0;
      #1;
      expect_v(K_RDY, (c == 32) ? 32'd1 : 32'd0, $sformatf("%s.c%0d", nm, c));
      if (c == 1) expect_v(K_RD1, 32'd0, {nm, ".clear_read"});
      if (c < 32) tick();
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int wait_cyc;
    rst = 1'b1; readReg1 = 5; readReg2 = 6; writeReg = '0; writeData = '0;
    regWrite = 1'b0; overflow = 1'b0; ovfSuppress = 1'b0;
    tick(); tick();
    #1;
    expect_v(K_RDY, 0, "rst.ready");
    expect_v(K_TRP, 0, "rst.trapped");
    expect_v(K_RD1, 0, "rst.rd1");
    expect_v(K_RD2, 0, "rst.rd2");
    chk_now({{(DW-1){1'b0}}, ready}, 0, "rst.state.ready");
    chk_now({{(DW-1){1'b0}}, trapped}, 0, "rst.state.trapped");
    chk_now(readData1, 0, "rst.state.rd1");
    chk_now(readData2, 0, "rst.state.rd2");
    tick();

    rst = 1'b0;
    ready_walk("init");
    tick();
    for (int i = 1; i < 32; i++) begin
      a = AW'(i);
      rd_both(a, 0, $sformatf("init.r%0d", i));
    end

    wr(5, 32'hDEADBEEF, 0, 0);
    rd_both(5, 32'hDEADBEEF, "r5");
    wr(0, 32'h1234, 0, 0);
    rd_both(0, 0, "r0");

    wr(7, 32'h7FFFFFFF, 1, 1);
    #1; expect_v(K_TRP, 1, "sup.trapped");
    readReg1 = 7; #1; expect_v(K_RD1, 0, "sup.r7_unchanged");
    tick();
    #1; expect_v(K_TRP, 0, "sup.trap_one_cycle");
    writeReg = 7; writeData = 32'h1; overflow = 1; ovfSuppress = 1; regWrite = 1;
    tick();
    #1; expect_v(K_TRP, 1, "b2b.first");
    tick();
    regWrite = 0; overflow = 0; ovfSuppress = 0;
    #1; expect_v(K_TRP, 1, "b2b.second");
    tick();
    #1; expect_v(K_TRP, 0, "b2b.end");
    wr(0, 32'h5, 1, 1);
    #1; expect_v(K_TRP, 0, "sup.r0_notrap");
    wr(7, 32'h7FFFFFFF, 1, 0);
    #1; expect_v(K_TRP, 0, "ovf_nosup.trapped");
    rd_both(7, 32'h7FFFFFFF, "ovf_nosup.r7");

    readReg1 = 3; readReg2 = 3;
    writeReg = 3; writeData = 32'hA5A5A5A5; regWrite = 1;
    #1; expect_v(K_RD1, BYP ? 32'hA5A5A5A5 : 32'h0, "byp.r3_same_cycle");
    tick();
    regWrite = 0;
    #1; expect_v(K_RD1, 32'hA5A5A5A5, "byp.r3_next");
    readReg2 = 0; writeReg = 0; writeData = 32'h1234; regWrite = 1;
    #1; expect_v(K_RD2, 0, "byp.r0");
    tick();
    writeReg = 3; writeData = 32'h1111; overflow = 1; ovfSuppress = 1;
    #1; expect_v(K_RD1, 32'hA5A5A5A5, "byp.suppressed");
    tick();
    regWrite = 0; overflow = 0; ovfSuppress = 0;
    #1; expect_v(K_RD1, 32'hA5A5A5A5, "byp.suppressed_next");
    tick();

    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    readReg1 = 5; writeReg = 9; writeData = 32'h99; regWrite = 1;
    ready_walk("rst10");
    tick();
    rd_both(9, 0, "rst10.r9_nocommit");

    for (int i = 1; i < 32; i++) wr(AW'(i), DW'(i), 0, 0);
    rd_both(31, 31, "fill.r31");
    rd_both(17, 17, "fill.r17");
    rst = 1'b1; tick(); rst = 1'b0;
    wait_cyc = 0;
    while (!ready && wait_cyc < 64) begin tick(); wait_cyc++; end
    #1; expect_v(K_RDY, 1, "refill.ready_timeout");
    chk_now({{(DW-1){1'b0}}, (wait_cyc >= 64)}, 0, "refill.wait_expired");
    tick();
    for (int i = 1; i < 32; i++) rd_both(AW'(i), 0, $sformatf("refill.r%0d", i));

    tick();
    if (n_pass != n_chk) $display("FAIL %0d/%0d checks passed", n_pass, n_chk);
    else $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
